// File: rtl/hazard_scheduler.sv
// hazard_scheduler
// Read-after-write interlock for a 5-stage pipeline. Three shadow slots
// (EX, MEM, WB) hold the destination register of the writer that sits in
// IR_2, IR_3 and IR_4. When the instruction in ID reads a register that is
// still pending in a counted slot, the front end is stalled and a NOP is
// injected. A taken branch or jump in EX flushes ID instead.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   id_valid                 IR_1 holds a real instruction
//   id_rs, id_rt             source register fields
//   id_use_rs, id_use_rt     instruction reads rs / rt
//   id_wr_en, id_wr_reg      instruction writes the register file, and where
//   ex_taken                 taken beq or jump in EX
//   stall                    hold PC and IR_1
//   bubble                   load NOP into IR_2
//   flush                    load NOP into IR_1
//   pend_mask                one bit per register with a write in EX/MEM/WB
//   state                    FSM state (0 HOLD, 1 RUN, 2 STALL)
//   stall_cnt                saturating count of stalled cycles
//
// state | meaning
// HOLD  | first cycle after reset, pipeline front end held, NOP injected
// RUN   | normal issue
// STALL | previous cycle stalled on a hazard; behaves like RUN otherwise

module hazard_scheduler #(
   parameter bit WB_BYPASS = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_use_rs,
   input  logic        id_use_rt,
   input  logic        id_wr_en,
   input  logic [4:0]  id_wr_reg,
   input  logic        ex_taken,
   output logic        stall,
   output logic        bubble,
   output logic        flush,
   output logic [31:0] pend_mask,
   output logic [1:0]  state,
   output logic [15:0] stall_cnt
);

   typedef enum logic [1:0] {
      ST_HOLD  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        ex_v_q, ex_v_d, mem_v_q, mem_v_d, wb_v_q, wb_v_d;
   logic [4:0]  ex_r_q, ex_r_d, mem_r_q, mem_r_d, wb_r_q, wb_r_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        wb_counted;
   logic        hazard;

   // A source matches when it is non-zero and equals any valid counted slot.
   function automatic logic src_hit(input logic [4:0] src,
                                    input logic v0, input logic [4:0] r0,
                                    input logic v1, input logic [4:0] r1,
                                    input logic v2, input logic [4:0] r2);
      return (src != 5'd0) &&
             ((v0 && (r0 == src)) || (v1 && (r1 == src)) || (v2 && (r2 == src)));
   endfunction

   // With a write-first register file the WB writer is already visible to ID.
   assign wb_counted = wb_v_q && !WB_BYPASS;

   assign hazard = id_valid &&
      ((id_use_rs && src_hit(id_rs, ex_v_q, ex_r_q, mem_v_q, mem_r_q, wb_counted, wb_r_q)) ||
       (id_use_rt && src_hit(id_rt, ex_v_q, ex_r_q, mem_v_q, mem_r_q, wb_counted, wb_r_q)));

   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      bubble  = 1'b0;
      flush   = 1'b0;
      case (state_q)
         ST_HOLD: begin
            stall   = 1'b1;
            bubble  = 1'b1;
            state_d = ST_RUN;
         end
         default: begin
            if (ex_taken) begin
               flush   = 1'b1;
               bubble  = 1'b1;
               state_d = ST_RUN;
            end else if (hazard) begin
               stall   = 1'b1;
               bubble  = 1'b1;
               state_d = ST_STALL;
            end else begin
               state_d = ST_RUN;
            end
         end
      endcase
   end

   always_comb begin
      mem_v_d = ex_v_q;
      mem_r_d = ex_r_q;
      wb_v_d  = mem_v_q;
      wb_r_d  = mem_r_q;
      ex_v_d  = 1'b0;
      ex_r_d  = id_wr_reg;
      if (!bubble) begin
         ex_v_d = id_valid && id_wr_en && (id_wr_reg != 5'd0);
      end
      stall_cnt_d = stall_cnt_q;
      if ((state_q != ST_HOLD) && stall && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_HOLD;
         ex_v_q      <= 1'b0;
         ex_r_q      <= 5'd0;
         mem_v_q     <= 1'b0;
         mem_r_q     <= 5'd0;
         wb_v_q      <= 1'b0;
         wb_r_q      <= 5'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         ex_v_q      <= ex_v_d;
         ex_r_q      <= ex_r_d;
         mem_v_q     <= mem_v_d;
         mem_r_q     <= mem_r_d;
         wb_v_q      <= wb_v_d;
         wb_r_q      <= wb_r_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Valid slots never hold register 0, so $0 cannot appear in the mask.
   always_comb begin
      pend_mask = 32'd0;
      if (ex_v_q)  pend_mask[ex_r_q]  = 1'b1;
      if (mem_v_q) pend_mask[mem_r_q] = 1'b1;
      if (wb_v_q)  pend_mask[wb_r_q]  = 1'b1;
   end

   assign state     = state_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/hazard_scheduler.md
HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

Interface
REQ-001 Parameter WB_BYPASS, default 0: 1 = register file is write-first, so the WB slot is excluded from hazard matching.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 id_valid  input  1  ID stage (IR_1) holds a real instruction.
REQ-005 id_rs / id_rt  input  5 each  source register fields IR_1[25:21] / IR_1[20:16].
REQ-006 id_use_rs / id_use_rt  input  1 each  instruction reads rs / rt.
REQ-007 id_wr_en  input  1  instruction writes the register file (add, sub, addi, lw).
REQ-008 id_wr_reg  input  5  destination register (rd for R-type, rt for I-type).
REQ-009 ex_taken  input  1  beq taken or jump in EX this cycle.
REQ-010 stall  output  1  hold PC and IR_1.
REQ-011 bubble  output  1  load 32'b0 (NOP) into IR_2 instead of IR_1.
REQ-012 flush  output  1  load 32'b0 into IR_1.
REQ-013 pend_mask  output  32  bit n = 1 while a write to register n is pending in the EX/MEM/WB slots.
REQ-014 state  output  2  FSM state: 0 HOLD, 1 RUN, 2 STALL.
REQ-015 stall_cnt  output  16  count of stalled cycles.

Function
REQ-016 The block SHALL keep three shadow slots (EX, MEM, WB), each {valid, reg[4:0]}, that track the writer in IR_2, IR_3 and IR_4.
REQ-017 Each cycle: MEM<=EX, WB<=MEM; EX<={id_valid & id_wr_en & (id_wr_reg!=0), id_wr_reg} unless bubble=1, in which case EX<=invalid.
REQ-018 hazard = id_valid & ((id_use_rs & id_rs!=0 & id_rs matches any valid counted slot) | (same for rt)); counted slots are EX, MEM, plus WB if WB_BYPASS=0.
REQ-019 Register 0 SHALL never cause a hazard and never appear in pend_mask.
REQ-020 stall, bubble and flush SHALL be combinational from state, slots and inputs (zero-cycle latency).
REQ-021 HOLD: stall=1, bubble=1, flush=0; unconditionally -> RUN next cycle.
REQ-022 RUN/STALL with ex_taken=1: flush=1, bubble=1, stall=0; next state RUN. ex_taken has priority over hazard.
REQ-023 RUN/STALL with ex_taken=0 and hazard=1: stall=1, bubble=1, flush=0; next state STALL.
REQ-024 RUN/STALL with ex_taken=0 and hazard=0: all three outputs 0; next state RUN.
REQ-025 One hazard SHALL stall at most 3 cycles (2 if WB_BYPASS=1), because the matching slot drains out of the counted window.
REQ-026 pend_mask SHALL be the OR of the one-hot decode of all valid slots (EX, MEM, WB regardless of WB_BYPASS), driven from registered state.
REQ-027 stall_cnt SHALL increment by 1 on every edge where state is RUN or STALL and stall=1, and saturate at 16'hFFFF.
REQ-028 If ID and a slot both target the same register, there is no hazard unless ID also reads it.

Reset
REQ-029 When rst=0, regardless of clk: state=HOLD, all slots invalid, pend_mask=0, stall_cnt=0; outputs stall=1, bubble=1, flush=0.
REQ-030 Reset asserted mid-stall SHALL discard all pending slots; after release the first edge passes through HOLD, then RUN.

Verification
REQ-031 Release reset -> one cycle in HOLD (stall=1, bubble=1), then RUN with stall=0 and state=1.
REQ-032 WB_BYPASS=0; add $3 writer, then next instruction add $4,$3,$5 -> stall=1 for exactly 3 cycles, stall_cnt=3, pend_mask bit3 set over 3 cycles, then stall=0.
REQ-033 WB_BYPASS=1, same sequence -> stall=1 for exactly 2 cycles, stall_cnt=2.
REQ-034 Writer to $0, dependent reads $0 -> no stall, pend_mask=0.
REQ-035 Hazard pending and ex_taken=1 in the same cycle -> flush=1, bubble=1, stall=0, next state RUN.
REQ-036 rst pulsed low during the second stall cycle -> pend_mask=0 immediately, stall_cnt=0, HOLD, then RUN with no residual stall.
